// File: rtl/slot_allocator_pkg.sv
// Shared constants and helpers for the slot allocator slice.
// The index-width helper keeps the interface, top and encoder agreeing on widths.
package slot_allocator_pkg;

    localparam int DEFAULT_NUM_SLOTS = 8;

    function automatic int idx_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/slot_allocator_if.sv
// Allocate / release / status bundle between request issue logic and the slot allocator.
// The master side is the requester; the slave side is the allocator itself.
interface slot_allocator_if
    import slot_allocator_pkg::*;
#(
    parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
);
    localparam int IDX_WIDTH = idx_width(NUM_SLOTS);

    logic                 alloc_req;
    logic                 alloc_ready;
    logic [IDX_WIDTH-1:0] alloc_idx;
    logic                 free_en;
    logic [IDX_WIDTH-1:0] free_idx;
    logic                 flush_en;
    logic [NUM_SLOTS-1:0] busy_mask;
    logic [IDX_WIDTH:0]   busy_count;
    logic                 empty;
    logic                 error_bad_free;

    modport master (
        output alloc_req, free_en, free_idx, flush_en,
        input  alloc_ready, alloc_idx, busy_mask, busy_count, empty, error_bad_free
    );

    modport slave (
        input  alloc_req, free_en, free_idx, flush_en,
        output alloc_ready, alloc_idx, busy_mask, busy_count, empty, error_bad_free
    );

endinterface

// File: rtl/slot_allocator_lowest_clear_index.sv
// Combinational priority encoder: reports the lowest-numbered zero bit of in_bits.
// found is low only when every bit is set.
module lowest_clear_index
    import slot_allocator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_NUM_SLOTS
) (
    input  logic [WIDTH-1:0]            in_bits,
    output logic                        found,
    output logic [idx_width(WIDTH)-1:0] idx
);
    localparam int IW = idx_width(WIDTH);

    // Scanning downward lets the lowest clear bit overwrite any higher one.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!in_bits[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/slot_allocator.sv
// Busy-bitmap slot allocator: grants the lowest free slot, accepts releases and flush.
// The next candidate is encoded from the next-state mask and registered, so alloc_idx is a flop.
module slot_allocator
    import slot_allocator_pkg::*;
#(
    parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
    input  logic           clk,
    input  logic           reset_n,
    slot_allocator_if.slave bus
);
    localparam int IDX_WIDTH = idx_width(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] busy_mask_q;
    logic [NUM_SLOTS-1:0] next_mask;
    logic [IDX_WIDTH:0]   busy_count_q;
    logic [IDX_WIDTH:0]   next_count;
    logic                 cand_valid;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic                 error_q;
    logic                 alloc_ready;
    logic                 grant;
    logic                 free_hit;
    logic                 free_bad;
    logic                 enc_found;
    logic [IDX_WIDTH-1:0] enc_idx;

    assign alloc_ready = cand_valid & ~bus.flush_en;
    assign grant       = bus.alloc_req & alloc_ready;

    // A free aimed at the slot being granted this cycle sees it clear, so it counts as bad.
    assign free_hit = bus.free_en & ~bus.flush_en & busy_mask_q[bus.free_idx];
    assign free_bad = bus.free_en & ~bus.flush_en & ~busy_mask_q[bus.free_idx];

    always_comb begin
        next_mask  = busy_mask_q;
        next_count = busy_count_q;
        if (grant) begin
            next_mask[cand_idx] = 1'b1;
        end
        if (free_hit) begin
            next_mask[bus.free_idx] = 1'b0;
        end
        if (grant && !free_hit) begin
            next_count = busy_count_q + (IDX_WIDTH + 1)'(1);
        end else if (!grant && free_hit) begin
            next_count = busy_count_q - (IDX_WIDTH + 1)'(1);
        end
        if (bus.flush_en) begin
            next_mask  = '0;
            next_count = '0;
        end
    end

    lowest_clear_index #(
        .WIDTH(NUM_SLOTS)
    ) u_candidate (
        .in_bits(next_mask),
        .found  (enc_found),
        .idx    (enc_idx)
    );

    // When the pool fills up the old candidate index is simply held; it is unused until a slot frees.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_mask_q  <= '0;
            busy_count_q <= '0;
            cand_valid   <= 1'b1;
            cand_idx     <= '0;
            error_q      <= 1'b0;
        end else begin
            busy_mask_q  <= next_mask;
            busy_count_q <= next_count;
            cand_valid   <= enc_found;
            if (enc_found) begin
                cand_idx <= enc_idx;
            end
            error_q      <= free_bad;
        end
    end

    assign bus.alloc_ready    = alloc_ready;
    assign bus.alloc_idx      = cand_idx;
    assign bus.busy_mask      = busy_mask_q;
    assign bus.busy_count     = busy_count_q;
    assign bus.empty          = (busy_count_q == '0);
    assign bus.error_bad_free = error_q;

    count_matches_mask: assert property (@(posedge clk) disable iff (!reset_n)
        32'(busy_count_q) == $countones(busy_mask_q));

    candidate_is_free: assert property (@(posedge clk) disable iff (!reset_n)
        cand_valid |-> !busy_mask_q[cand_idx]);

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator: directed scenarios then randomized traffic,
// all checked against a slot-array reference model.
module tb_slot_allocator;

    localparam int N  = 8;
    localparam int IW = 3;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    bit   model_busy [N];
    bit   model_err;

    slot_allocator_if #(.NUM_SLOTS(N)) bus ();

    slot_allocator #(.NUM_SLOTS(N)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += model_busy[i] ? 1 : 0;
        return c;
    endfunction

    function automatic int model_lowest_free();
        for (int i = 0; i < N; i++) if (!model_busy[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = model_busy[i];
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".busy_mask"},  64'(bus.busy_mask),      64'(model_mask()));
        checkOutput({tag, ".busy_count"}, 64'(bus.busy_count),     64'(model_count()));
        checkOutput({tag, ".empty"},      64'(bus.empty),          64'(model_count() == 0));
        checkOutput({tag, ".error"},      64'(bus.error_bad_free), 64'(model_err));
    endtask

    // Called just after a rising edge: drives one cycle, checks pre-edge outputs, then post-edge state.
    task automatic applyStimulus(input string tag, input bit req, input bit fen,
                                 input int fidx, input bit flush);
        bit exp_ready;
        int gidx;
        bit grant;
        bit good_free;
        bus.alloc_req = req;
        bus.free_en   = fen;
        bus.free_idx  = IW'(fidx);
        bus.flush_en  = flush;
        #2;
        gidx      = model_lowest_free();
        exp_ready = !flush && (gidx >= 0);
        checkOutput({tag, ".alloc_ready"}, 64'(bus.alloc_ready), 64'(exp_ready));
        if (exp_ready) checkOutput({tag, ".alloc_idx"}, 64'(bus.alloc_idx), 64'(gidx));
        grant     = req && exp_ready;
        good_free = fen && !flush && model_busy[fidx];
        @(posedge clk);
        #1;
        model_err = fen && !flush && !good_free;
        if (flush) begin
            for (int i = 0; i < N; i++) model_busy[i] = 1'b0;
        end else begin
            if (grant) model_busy[gidx] = 1'b1;
            if (good_free) model_busy[fidx] = 1'b0;
        end
        checkState(tag);
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) model_busy[i] = 1'b0;
        model_err = 1'b0;
    endtask

    initial begin
        int f;
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.alloc_req = 1'b0;
        bus.free_en   = 1'b0;
        bus.free_idx  = '0;
        bus.flush_en  = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkState("reset");
        checkOutput("reset.alloc_ready", 64'(bus.alloc_ready), 64'd1);
        checkOutput("reset.alloc_idx",   64'(bus.alloc_idx),   64'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the pool in order, then confirm it refuses further grants.
        for (int i = 0; i < N; i++) applyStimulus("fill", 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("full", 1'b1, 1'b0, 0, 1'b0);
        checkOutput("full.mask",  64'(bus.busy_mask),  64'hFF);
        checkOutput("full.count", 64'(bus.busy_count), 64'd8);

        applyStimulus("free5", 1'b0, 1'b1, 5, 1'b0);
        checkOutput("free5.idx", 64'(bus.alloc_idx), 64'd5);
        applyStimulus("regrant5", 1'b1, 1'b0, 0, 1'b0);
        checkOutput("regrant5.mask", 64'(bus.busy_mask), 64'hFF);

        // Grant slot 4 and free slot 1 in the same cycle starting from 8'h0F.
        applyStimulus("flushA", 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus("fill4", 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("grantfree", 1'b1, 1'b1, 1, 1'b0);
        checkOutput("grantfree.mask",  64'(bus.busy_mask),  64'h1D);
        checkOutput("grantfree.count", 64'(bus.busy_count), 64'd4);
        checkOutput("grantfree.next",  64'(bus.alloc_idx),  64'd1);

        // Bad free on mask 8'h03 must pulse the error for exactly one cycle.
        applyStimulus("flushB", 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus("fill2", 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("badfree", 1'b0, 1'b1, 6, 1'b0);
        checkOutput("badfree.pulse", 64'(bus.error_bad_free), 64'd1);
        applyStimulus("badfree.after", 1'b0, 1'b0, 0, 1'b0);
        checkOutput("badfree.cleared", 64'(bus.error_bad_free), 64'd0);
        applyStimulus("freecand", 1'b1, 1'b1, 2, 1'b0);

        // Build 8'hA5 then flush while requesting.
        applyStimulus("flushC", 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++) applyStimulus("fill8", 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("freeA", 1'b0, 1'b1, 1, 1'b0);
        applyStimulus("freeB", 1'b0, 1'b1, 3, 1'b0);
        applyStimulus("freeC", 1'b0, 1'b1, 4, 1'b0);
        applyStimulus("freeD", 1'b0, 1'b1, 6, 1'b0);
        checkOutput("a5.mask", 64'(bus.busy_mask), 64'hA5);
        applyStimulus("flushreq", 1'b1, 1'b0, 0, 1'b1);
        checkOutput("flushreq.idx", 64'(bus.alloc_idx), 64'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) applyStimulus("burst", 1'b1, 1'b0, 0, 1'b0);
        bus.alloc_req = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkState("asyncrst");
        checkOutput("asyncrst.alloc_idx",   64'(bus.alloc_idx),   64'd0);
        checkOutput("asyncrst.alloc_ready", 64'(bus.alloc_ready), 64'd1);
        @(posedge clk);
        #2;
        bus.alloc_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("postrst", 1'b0, 1'b0, 0, 1'b0);

        // Randomized traffic, with frees biased toward currently busy slots.
        for (int n = 0; n < 400; n++) begin
            f = $urandom_range(N - 1);
            if (($urandom % 4) != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (model_busy[(f + k) % N]) begin
                        f = (f + k) % N;
                        break;
                    end
                end
            end
            applyStimulus("rand", ($urandom % 3) != 0, ($urandom % 3) == 0, f,
                          ($urandom % 40) == 0);
        end

        $display("[TB] TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
